frame_tx: RTL and testbench
===========================

Name: frame_tx

Overview:
- Transmit-side framer for the UART pixel link.
- Takes the 8-bit edge-magnitude pixel stream from the pipeline and emits a byte stream for the UART transmitter.
- Each frame on the wire is:
  - a 6-byte header: sync word and frame dimensions;
  - every pixel replicated REPL_P times (host reads it back as RGB);
  - a 1-byte additive checksum trailer.
- Replaces the magnitude elastic/unpack stage feeding the UART TX, and is the counterpart of the host-side frame receiver.

Parameters:
- WIDTH_P, 8, pixel width in bits; must be 8.
- LINE_W_P, 640, pixels per line (1..65535).
- LINES_P, 480, lines per frame (1..65535).
- REPL_P, 3, output bytes per pixel (1..4).
- SYNC0_P, 8'hA5, first header byte.
- SYNC1_P, 8'h5A, second header byte.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset: synchronous, active-high, sampled on rising clk_i.
- data_i  in  WIDTH_P  pixel value.
- valid_i  in  1  pixel valid.
- ready_o  out  1  pixel accepted when valid_i & ready_o.
- data_o  out  8  byte to UART TX.
- valid_o  out  1  byte valid.
- ready_i  in  1  byte accepted when valid_o & ready_i.
- frame_done_o  out  1  one-cycle pulse on the cycle the trailer byte is accepted.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE; all counters and checksum cleared.
  - Outputs: valid_o=0, ready_o=0, data_o=8'h00, frame_done_o=0.
  - Reset mid-frame abandons the frame with no trailer; the next frame starts with a full header.
- States: IDLE -> HDR -> PIX -> TRL -> IDLE.
- IDLE:
  - Outputs: valid_o=0, ready_o=0, data_o=0.
  - valid_i=1 moves to HDR next cycle. The pixel is NOT consumed.
  - hdr_idx=0; checksum cleared.
- HDR:
  - valid_o=1, ready_o=0.
  - data_o by hdr_idx:
    - 0: SYNC0_P
    - 1: SYNC1_P
    - 2: LINE_W_P[7:0]
    - 3: LINE_W_P[15:8]
    - 4: LINES_P[7:0]
    - 5: LINES_P[15:8]
  - hdr_idx advances only on ready_i.
  - Acceptance at idx 5 moves to PIX with rep_cnt=0, col=0, row=0.
- PIX (pass-through, zero latency):
  - valid_o=valid_i, data_o=data_i.
  - ready_o = ready_i & (rep_cnt==REPL_P-1).
  - Each byte handshake (valid_i & ready_i) increments rep_cnt; it wraps to 0 after REPL_P-1.
  - On pixel acceptance:
    - checksum += data_i, mod 256;
    - col++;
    - col==LINE_W_P-1 wraps col to 0 and increments row.
  - Acceptance of pixel (col=LINE_W_P-1, row=LINES_P-1) moves to TRL.
  - Replicas of one pixel are contiguous; no header or trailer byte interleaves.
  - valid_i deasserting mid-replica stalls the output with rep_cnt held. Upstream obeys AXI-stream stability, so data_i is unchanged.
- TRL:
  - valid_o=1, data_o=checksum, ready_o=0.
  - On ready_i: frame_done_o=1 for that cycle, state goes to IDLE.
- General handshake rules:
  - valid_o never depends on ready_i.
  - Once valid_o rises in HDR/TRL, data_o is held until accepted.
- Back-to-back frames:
  - IDLE costs exactly one bubble cycle between the trailer and the next SYNC0_P.
  - A pixel pending at the trailer waits through the header.
- Throughput in PIX: one byte/cycle when ready_i=1 and valid_i=1.
- Frame length: 6 + REPL_P·LINE_W_P·LINES_P + 1 bytes.
- Counters: col/row are 16-bit; rep_cnt is 2-bit; hdr_idx is 3-bit.
- No assertion of ready_o outside PIX.

Test Plan (LINE_W_P=4, LINES_P=2, REPL_P=3 unless stated):
1. Reset, then pixels 1..8 with valid_i and ready_i held 1 -> bytes A5 5A 04 00 02 00, then 01 01 01 02 02 02 … 08 08 08, then 24 (sum 36 = 0x24). frame_done_o pulses once on the trailer; 31 bytes total.
2. Same frame with ready_i toggling 1/0 every cycle and valid_i random -> identical byte sequence. No byte is dropped or duplicated. data_o is stable while valid_o & ~ready_i.
3. Pixels 8'hFF ×8 -> every pixel byte FF; trailer 8'hF8 (2040 mod 256) confirms checksum wrap.
4. Two frames back-to-back with continuous valid_i -> second A5 appears exactly 2 cycles after the first trailer handshake. The checksum restarts, so frame 2 with pixels all 0 gives trailer 00.
5. rst_i asserted after 3 pixels, then a new frame -> outputs go to 0 the cycle after the reset edge. The new frame begins with the full 6-byte header; no trailer from the aborted frame appears.
6. REPL_P=1, LINE_W_P=1, LINES_P=1, pixel 8'h7E -> A5 5A 01 00 01 00 7E 7E; ready_o is high only during the single PIX byte.

Source files
------------

// File: rtl/frame_tx.sv
// frame_tx: frames the 8-bit pixel stream into header + replicated pixels + checksum bytes for UART TX
// Ports: clk_i/rst_i clock and sync active-high reset; data_i/valid_i/ready_o pixel input stream;
//        data_o/valid_o/ready_i byte output stream; frame_done_o pulses when the trailer byte is taken.
module frame_tx #(
  parameter int WIDTH_P = 8,
  parameter int LINE_W_P = 640,
  parameter int LINES_P = 480,
  parameter int REPL_P = 3,
  parameter logic [7:0] SYNC0_P = 8'hA5,
  parameter logic [7:0] SYNC1_P = 8'h5A
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [7:0]         data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               frame_done_o
);
  typedef enum logic [1:0] {IDLE, HDR, PIX, TRL} state_t;
  state_t      r_state;
  logic [2:0]  r_hdr_idx;
  logic [1:0]  r_rep;
  logic [15:0] r_col, r_row;
  logic [7:0]  r_sum;
  logic [15:0] w_lw, w_ln;
  logic [7:0]  w_hdr;
  logic        w_last_rep, w_pix_acc;
  assign w_lw = 16'(LINE_W_P);
  assign w_ln = 16'(LINES_P);
  assign w_last_rep = r_rep == 2'(REPL_P - 1);
  // a pixel is consumed only on its final replica byte
  assign w_pix_acc = (r_state == PIX) & valid_i & ready_i & w_last_rep;
  assign w_hdr = r_hdr_idx == 3'd0 ? SYNC0_P :
                 r_hdr_idx == 3'd1 ? SYNC1_P :
                 r_hdr_idx == 3'd2 ? w_lw[7:0] :
                 r_hdr_idx == 3'd3 ? w_lw[15:8] :
                 r_hdr_idx == 3'd4 ? w_ln[7:0] : w_ln[15:8];
  // PIX is a zero-latency pass-through, so outputs decode the registered state directly
  always_comb begin
    valid_o = (r_state == HDR) | (r_state == TRL) | ((r_state == PIX) & valid_i);
    ready_o = (r_state == PIX) & ready_i & w_last_rep;
    data_o = r_state == HDR ? w_hdr : r_state == TRL ? r_sum : r_state == PIX ? data_i : 8'h00;
    frame_done_o = (r_state == TRL) & ready_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_hdr_idx <= '0;
      r_rep <= '0;
      r_col <= '0;
      r_row <= '0;
      r_sum <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hdr_idx <= '0;
          r_sum <= '0;
          if (valid_i) r_state <= HDR;
        end
        HDR: if (ready_i) begin
          r_hdr_idx <= r_hdr_idx + 3'd1;
          if (r_hdr_idx == 3'd5) begin
            r_state <= PIX;
            r_rep <= '0;
            r_col <= '0;
            r_row <= '0;
          end
        end
        PIX: begin
          if (valid_i & ready_i) r_rep <= w_last_rep ? 2'd0 : r_rep + 2'd1;
          if (w_pix_acc) begin
            r_sum <= r_sum + data_i;
            if (r_col == w_lw - 16'd1) begin
              r_col <= '0;
              r_row <= r_row + 16'd1;
              if (r_row == w_ln - 16'd1) r_state <= TRL;
            end else begin
              r_col <= r_col + 16'd1;
            end
          end
        end
        default: if (ready_i) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: scoreboard bench for frame_tx with directed pixel frames
module tb_frame_tx;
  logic clk = 0;
  logic rst_i = 1;
  always #5 clk = ~clk;
  logic [7:0] data_i = 0, data_o;
  logic valid_i = 0, ready_i = 1, ready_o, valid_o, frame_done_o;
  frame_tx #(.LINE_W_P(4), .LINES_P(2), .REPL_P(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .frame_done_o(frame_done_o));
  logic [7:0] d6_i = 8'h7E, d6_o;
  logic v6_i = 0, r6_o, v6_o, done6;
  frame_tx #(.LINE_W_P(1), .LINES_P(1), .REPL_P(1)) dut6 (
    .clk_i(clk), .rst_i(rst_i), .data_i(d6_i), .valid_i(v6_i), .ready_o(r6_o),
    .data_o(d6_o), .valid_o(v6_o), .ready_i(1'b1), .frame_done_o(done6));
  typedef struct {logic [7:0] d; logic last; logic gap;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_bytes = 0, n_done = 0, trl_cyc = -100;
  logic rmode = 0, vrand = 0, stall = 0;
  logic [7:0] stall_d = 0;
  logic [7:0] p_inc[8], p_ff[8], p_zero[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask
  task automatic push_frame(input logic [7:0] px[8], input logic gap);
    logic [7:0] s = 0;
    logic [7:0] hdr[6] = '{8'hA5, 8'h5A, 8'h04, 8'h00, 8'h02, 8'h00};
    for (int i = 0; i < 6; i++) q.push_back('{hdr[i], 1'b0, i == 0 ? gap : 1'b0});
    for (int i = 0; i < 8; i++) begin
      s += px[i];
      for (int r = 0; r < 3; r++) q.push_back('{px[i], 1'b0, 1'b0});
    end
    q.push_back('{s, 1'b1, 1'b0});
  endtask
  task automatic send_pixel(input logic [7:0] d);
    logic acc = 0;
    data_i = d;
    valid_i = vrand ? ($urandom_range(0, 2) != 0) : 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = valid_i & ready_o;
      @(posedge clk);
      #1;
      if (!acc && vrand) valid_i = $urandom_range(0, 3) != 0;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pixel_timeout: got no acceptance expected acceptance of %0h", d);
    end
    valid_i = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
    chk("drain_left", 32'(q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    ready_i = rmode ? ~ready_i : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (rst_i) stall = 0;
    else begin
      if (stall && valid_o) chk("hold", {24'b0, data_o}, {24'b0, stall_d});
      if (frame_done_o) n_done++;
      if (valid_o && ready_i) begin
        n_bytes++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte: got %0h expected none", data_o);
        end else begin
          e_m = q.pop_front();
          chk("byte", {24'b0, data_o}, {24'b0, e_m.d});
          chk("done", {31'b0, frame_done_o}, {31'b0, e_m.last});
          if (e_m.gap) chk("gap", cyc - trl_cyc, 2);
          if (e_m.last) trl_cyc = cyc;
        end
      end else if (frame_done_o) chk("done_no_hs", {31'b0, frame_done_o}, 0);
      stall = valid_o && !ready_i;
      stall_d = data_o;
    end
  end
  initial begin
    logic [7:0] e6[8] = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h7E};
    logic [7:0] b6[$];
    int r6_cnt = 0, d6_cnt = 0;
    logic acc6;
    for (int i = 0; i < 8; i++) begin
      p_inc[i] = 8'(i + 1);
      p_ff[i] = 8'hFF;
      p_zero[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    chk("rst_valid_o", {31'b0, valid_o}, 0);
    chk("rst_ready_o", {31'b0, ready_o}, 0);
    chk("rst_data_o", {24'b0, data_o}, 0);
    chk("rst_done", {31'b0, frame_done_o}, 0);
    chk("rst_valid6", {31'b0, v6_o}, 0);
    @(posedge clk);
    #1;
    push_frame(p_inc, 0);
    for (int i = 0; i < 8; i++) send_pixel(p_inc[i]);
    drain();
    chk("t1_bytes", n_bytes, 31);
    chk("t1_done", n_done, 1);
    rmode = 1;
    vrand = 1;
    push_frame(p_inc, 0);
    for (int i = 0; i < 8; i++) send_pixel(p_inc[i]);
    drain();
    rmode = 0;
    vrand = 0;
    chk("t2_bytes", n_bytes, 62);
    chk("t2_done", n_done, 2);
    push_frame(p_ff, 0);
    for (int i = 0; i < 8; i++) send_pixel(p_ff[i]);
    drain();
    push_frame(p_inc, 0);
    push_frame(p_zero, 1);
    for (int i = 0; i < 8; i++) send_pixel(p_inc[i]);
    for (int i = 0; i < 8; i++) send_pixel(p_zero[i]);
    drain();
    chk("t4_done", n_done, 5);
    push_frame(p_inc, 0);
    for (int i = 0; i < 3; i++) send_pixel(p_inc[i]);
    rst_i = 1;
    @(posedge clk);
    #1 rst_i = 0;
    q.delete();
    @(negedge clk);
    chk("t5_valid_o", {31'b0, valid_o}, 0);
    chk("t5_ready_o", {31'b0, ready_o}, 0);
    chk("t5_data_o", {24'b0, data_o}, 0);
    @(posedge clk);
    #1;
    push_frame(p_inc, 0);
    for (int i = 0; i < 8; i++) send_pixel(p_inc[i]);
    drain();
    chk("t5_done", n_done, 6);
    v6_i = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v6_o) b6.push_back(d6_o);
      r6_cnt += int'(r6_o);
      d6_cnt += int'(done6);
      acc6 = v6_i & r6_o;
      @(posedge clk);
      #1;
      if (acc6) v6_i = 0;
    end
    chk("t6_len", 32'(b6.size()), 8);
    for (int i = 0; i < 8 && i < b6.size(); i++) chk("t6_byte", {24'b0, b6[i]}, {24'b0, e6[i]});
    chk("t6_ready_cycles", r6_cnt, 1);
    chk("t6_done", d6_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
